uart_rx_tx_gen: RTL and testbench

UART_RX_TX_GEN -- requirements
Module: uart_rx_tx_gen

---
 rtl/uart_rx_tx_gen.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_tx_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_tx_gen.sv
// 8N1 UART receiver plus a periodic transmit-frame generator reporting the last received byte as "RX:hh....\r\n".
// Receiver and transmitter share only the delayed rx_data snapshot taken at frame start.
module uart_rx_tx_gen #(
  parameter int unsigned BPS_NUM      = 1296,
  parameter int unsigned FRAME_PERIOD = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic [7:0] write_max_num,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_en,
  output logic       rx_finish,
  output logic       tx_busy
);
  // state | meaning
  // IDLE  | waiting for synchronized falling edge, rx_finish high
  // START | counting to mid start bit, rejects glitches
  // DATA  | sampling d0..d7 mid-bit, LSB first
  // STOP  | sampling stop bit, commits byte when high
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic [15:0] BIT_LAST    = 16'(BPS_NUM - 1);
  localparam logic [15:0] HALF_LAST   = 16'(BPS_NUM / 2 - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(FRAME_PERIOD - 1);

  rx_state_t   rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  logic [15:0] tx_cnt;
  logic [3:0]  tx_bits;
  logic [8:0]  tx_shift;

  logic [31:0] period_cnt;
  logic        frame_active, wr_pulse;
  logic [7:0]  wr_byte, frame_n, byte_idx, snap, rx_d1, snap_src, frame_byte, hex;
  logic [3:0]  nib;

  assign rx_finish = (rx_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:  if (rx_prev && !rx_s2) rx_next = START;
      START: if (rx_cnt == 16'd0) rx_next = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_cnt == 16'd0 && rx_bit == 3'd7) rx_next = STOP;
      STOP:  if (rx_cnt == 16'd0) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_data  <= 8'd0;
      rx_en    <= 1'b0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_en   <= 1'b0;
      case (rx_state)
        IDLE: begin
          rx_cnt <= HALF_LAST;
          rx_bit <= 3'd0;
        end
        START: rx_cnt <= (rx_cnt == 16'd0) ? BIT_LAST : rx_cnt - 16'd1;
        DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_cnt   <= BIT_LAST;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        STOP: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s2) begin
              rx_data <= rx_shift;
              rx_en   <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_cnt <= 16'd0;
      endcase
    end
  end

  // Start bit goes out on the same edge that accepts the write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= 16'd0;
      tx_bits  <= 4'd0;
      tx_shift <= 9'h1ff;
    end else if (!tx_busy) begin
      uart_tx <= 1'b1;
      if (wr_pulse) begin
        tx_busy  <= 1'b1;
        uart_tx  <= 1'b0;
        tx_shift <= {1'b1, wr_byte};
        tx_cnt   <= BIT_LAST;
        tx_bits  <= 4'd9;
      end
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else if (tx_bits == 4'd0) begin
      tx_busy <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      uart_tx  <= tx_shift[0];
      tx_shift <= {1'b1, tx_shift[8:1]};
      tx_bits  <= tx_bits - 4'd1;
      tx_cnt   <= BIT_LAST;
    end
  end

  always_comb begin
    nib = (byte_idx == 8'd3) ? snap[7:4] : snap[3:0];
    hex = (nib < 4'd10) ? 8'h30 + {4'd0, nib} : 8'h37 + {4'd0, nib};
    if (byte_idx == 8'd0)                     frame_byte = 8'h52;
    else if (byte_idx == 8'd1)                frame_byte = 8'h58;
    else if (byte_idx == 8'd2)                frame_byte = 8'h3a;
    else if (byte_idx == 8'd3 || byte_idx == 8'd4) frame_byte = hex;
    else if (byte_idx == frame_n - 8'd1)      frame_byte = 8'h0a;
    else if (byte_idx == frame_n - 8'd2)      frame_byte = 8'h0d;
    else                                      frame_byte = 8'h2e;
  end

  // Frame stays active until the last character has fully left the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt   <= PERIOD_LAST;
      frame_active <= 1'b0;
      wr_pulse     <= 1'b0;
      wr_byte      <= 8'd0;
      frame_n      <= 8'd0;
      byte_idx     <= 8'd0;
      snap         <= 8'd0;
      rx_d1        <= 8'd0;
      snap_src     <= 8'd0;
    end else begin
      rx_d1      <= rx_data;
      snap_src   <= rx_d1;
      period_cnt <= (period_cnt == 32'd0) ? PERIOD_LAST : period_cnt - 32'd1;
      wr_pulse   <= 1'b0;
      if (!frame_active) begin
        if (period_cnt == 32'd0) begin
          frame_n      <= (write_max_num != 8'd0 && write_max_num < 8'd7) ? 8'd7 : write_max_num;
          snap         <= snap_src;
          byte_idx     <= 8'd0;
          frame_active <= (write_max_num != 8'd0);
        end
      end else if (!tx_busy && !wr_pulse) begin
        if (byte_idx < frame_n) begin
          wr_pulse <= 1'b1;
          wr_byte  <= frame_byte;
          byte_idx <= byte_idx + 8'd1;
        end else begin
          frame_active <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_tx_gen.sv
// Directed bench for uart_rx_tx_gen: serial receive cases, decoded transmit frames, busy timing, frame-length boundaries.
module tb_uart_rx_tx_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] write_max_num = 8'h14;
  logic       uart_tx, rx_en, rx_finish, tx_busy;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tx_low_cnt = 0;
  int busy_cnt = 0;
  int first_low = -1;
  int rx_en_cnt = 0;
  int fin_run = 0;
  int fin_last_run = 0;
  int stop_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int rise_q[$];
  int fall_q[$];

  uart_rx_tx_gen #(.BPS_NUM(16), .FRAME_PERIOD(4000)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .write_max_num(write_max_num),
    .uart_tx(uart_tx), .rx_data(rx_data), .rx_en(rx_en), .rx_finish(rx_finish), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) cyc++;
  end

  initial begin : mon
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (uart_tx === 1'b0) begin
          tx_low_cnt++;
          if (first_low < 0) first_low = cyc;
        end
        if (tx_busy === 1'b1) busy_cnt++;
        if (tx_busy === 1'b1 && !busy_prev) rise_q.push_back(cyc);
        if (tx_busy === 1'b0 && busy_prev) fall_q.push_back(cyc);
        busy_prev = tx_busy;
        if (rx_en === 1'b1) rx_en_cnt++;
        if (rx_finish === 1'b0) fin_run++;
        else if (fin_run > 0) begin
          fin_last_run = fin_run;
          fin_run = 0;
        end
      end
    end
  end

  initial begin : dec
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (16) @(negedge clk);
        if (uart_tx !== 1'b1) stop_err++;
        tx_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic build_frame(input logic [7:0] hi, input logic [7:0] lo, input int n);
    exp_q = {};
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h58);
    exp_q.push_back(8'h3a);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
    for (int i = 5; i < n - 2; i++) exp_q.push_back(8'h2e);
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endtask

  task automatic check_frame(input string name);
    check($sformatf("%s_len", name), tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'hffff_ffff, {24'd0, exp_q[i]});
    tx_q = {};
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_en", rx_en, 0);
    check("rst_rx_finish", rx_finish, 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    fork
      send_byte(8'ha5, 1'b1);
      begin
        repeat (80) @(negedge clk);
        check("a5_finish_mid", rx_finish, 0);
      end
    join
    check("a5_rx_data", rx_data, 8'ha5);
    check("a5_rx_en_once", rx_en_cnt, 1);
    check("a5_finish_back", rx_finish, 1);
    check("a5_finish_span", (fin_last_run >= 144 && fin_last_run <= 160), 1);

    send_byte(8'h3c, 1'b0);
    check("frame_err_rx_data", rx_data, 8'ha5);
    check("frame_err_rx_en", rx_en_cnt, 1);

    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_finish", rx_finish, 1);
    check("glitch_rx_en", rx_en_cnt, 1);

    send_byte(8'h5e, 1'b1);
    check("5e_rx_data", rx_data, 8'h5e);
    check("5e_rx_en", rx_en_cnt, 2);

    wait_cyc(3999);
    check("quiet_after_reset", tx_low_cnt, 0);
    wait_cyc(4100);
    check("first_low_after_3999", (first_low > 3999 && first_low < 4010), 1);
    write_max_num = 8'h03;

    wait_cyc(7800);
    build_frame("5", "E", 20);
    check_frame("frame1");
    check("frame1_windows", fall_q.size(), 20);
    for (int i = 0; i < rise_q.size() && i < fall_q.size(); i++)
      check($sformatf("frame1_busy_len%0d", i), fall_q[i] - rise_q[i], 160);
    for (int i = 0; i + 1 < rise_q.size() && i < fall_q.size(); i++)
      check($sformatf("frame1_gap%0d", i), (rise_q[i+1] - fall_q[i]) <= 2, 1);
    rise_q = {};
    fall_q = {};

    wait_cyc(8100);
    write_max_num = 8'h14;
    wait_cyc(11800);
    build_frame("5", "E", 7);
    check_frame("frame2_n3");

    wait_cyc(12500);
    send_byte(8'h81, 1'b1);
    check("duplex_rx_data", rx_data, 8'h81);
    check("duplex_rx_en", rx_en_cnt, 3);
    write_max_num = 8'h07;
    wait_cyc(15800);
    build_frame("5", "E", 20);
    check_frame("frame3_duplex");

    wait_cyc(16100);
    write_max_num = 8'h00;
    wait_cyc(17500);
    build_frame("8", "1", 7);
    check_frame("frame4_81");

    begin
      int low0, busy0;
      low0 = tx_low_cnt;
      busy0 = busy_cnt;
      wait_cyc(32100);
      check("n0_tx_quiet", tx_low_cnt - low0, 0);
      check("n0_busy_quiet", busy_cnt - busy0, 0);
      check("n0_no_bytes", tx_q.size(), 0);
    end
    check("tx_stop_bits", stop_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
